// File: rtl/pool_stride_decimator.sv
// pool_stride_decimator
// Takes the stride-1 stream of pooled window results, tracks the raster
// position of each accepted beat and forwards only the windows that lie fully
// inside the image and sit on the stride grid. The last kept window of each
// frame is flagged with frame_done so the next layer can close its frame.
// Window position is the bottom-right pixel of the window.

module pool_stride_decimator #(
    parameter int D_WIDTH     = 8,
    parameter int CHANNELS    = 4,
    parameter int FILTER_SIZE = 2,
    parameter int IMAGE_SIZE  = 28,
    parameter int STRIDE      = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_en,
    input  logic [D_WIDTH*CHANNELS-1:0]   input_data,
    input  logic                          in_valid,
    output logic [D_WIDTH*CHANNELS-1:0]   output_data,
    output logic                          valid,
    output logic                          frame_done
);

    localparam int OUT_SIZE = (IMAGE_SIZE - FILTER_SIZE) / STRIDE + 1;
    localparam int CW       = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int PW       = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int DW       = D_WIDTH * CHANNELS;

    // First full-window position and last position that still lands on the grid.
    localparam logic [CW-1:0] POS_FIRST = CW'(FILTER_SIZE - 1);
    localparam logic [CW-1:0] POS_LAST  = CW'(FILTER_SIZE - 1 + (OUT_SIZE - 1) * STRIDE);
    localparam logic [CW-1:0] POS_MAX   = CW'(IMAGE_SIZE - 1);
    localparam logic [PW-1:0] PH_MAX    = PW'(STRIDE - 1);

    if (STRIDE < 1) begin : g_bad_stride
        $error("pool_stride_decimator: STRIDE must be >= 1");
    end
    if (FILTER_SIZE < 1) begin : g_bad_filter
        $error("pool_stride_decimator: FILTER_SIZE must be >= 1");
    end
    if (IMAGE_SIZE < FILTER_SIZE) begin : g_bad_image
        $error("pool_stride_decimator: IMAGE_SIZE must be >= FILTER_SIZE");
    end

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [PW-1:0] col_phase_q, col_phase_d;
    logic [PW-1:0] row_phase_q, row_phase_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;

    logic accept;
    logic col_full, row_full;
    logic col_in, row_in;
    logic keep;
    logic last_pos;

    // Keep decision for the current raster position.
    always_comb begin
        accept   = clk_en & in_valid;
        col_full = (col_q >= POS_FIRST);
        row_full = (row_q >= POS_FIRST);
        col_in   = (col_q <= POS_LAST);
        row_in   = (row_q <= POS_LAST);
        keep     = col_full & row_full & col_in & row_in &
                   (col_phase_q == '0) & (row_phase_q == '0);
        last_pos = (col_q == POS_LAST) & (row_q == POS_LAST);
    end

    // Raster position and stride phase advance; phases stay at 0 until the
    // first full window so that phase 0 always marks a grid position.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        col_phase_d = col_phase_q;
        row_phase_d = row_phase_q;
        if (accept) begin
            if (col_q == POS_MAX) begin
                col_d       = '0;
                col_phase_d = '0;
                if (row_q == POS_MAX) begin
                    row_d       = '0;
                    row_phase_d = '0;
                end else begin
                    row_d = row_q + 1'b1;
                    if (!row_full || row_phase_q == PH_MAX) begin
                        row_phase_d = '0;
                    end else begin
                        row_phase_d = row_phase_q + 1'b1;
                    end
                end
            end else begin
                col_d = col_q + 1'b1;
                if (!col_full || col_phase_q == PH_MAX) begin
                    col_phase_d = '0;
                end else begin
                    col_phase_d = col_phase_q + 1'b1;
                end
            end
        end
    end

    // Output stage: one enabled cycle of latency, data holds between kept beats.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        data_d  = data_q;
        if (clk_en) begin
            valid_d = accept & keep;
            done_d  = accept & keep & last_pos;
            if (accept & keep) begin
                data_d = input_data;
            end
        end
    end

    // State registers; every next value already holds when clk_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            col_phase_q <= '0;
            row_phase_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            col_phase_q <= col_phase_d;
            row_phase_q <= row_phase_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    assign output_data = data_q;
    assign valid       = valid_q;
    assign frame_done  = done_q;

endmodule

// File: doc/pool_stride_decimator.md
Name: pool_stride_decimator

Overview:
- Sits directly downstream of the pooling layer and consumes its per-pixel window results (D_WIDTH*CHANNELS bus plus valid).
- The pooling layer emits one max-pooled result per input pixel, i.e. stride 1.
- This block tracks raster position and forwards only results whose window is fully inside the image and aligned to STRIDE, producing the decimated OUT_SIZE x OUT_SIZE feature map.
- It also flags the last output of each frame for the next layer.

Parameters:
- D_WIDTH, 8, bits per channel sample.
- CHANNELS, 4, number of parallel channels on the data bus.
- FILTER_SIZE, 2, pooling window edge length. Window position is given by the bottom-right pixel of the window.
- IMAGE_SIZE, 28, input feature-map edge length in pixels.
- STRIDE, 2, pooling stride.
- OUT_SIZE, (IMAGE_SIZE-FILTER_SIZE)/STRIDE+1, derived output edge length. Not to be overridden.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- clk_en  input  1  global pipeline enable. All state advances only when it is 1.
- input_data  input  D_WIDTH*CHANNELS  pooled window result, channel i at bits [D_WIDTH*(i+1)-1 : D_WIDTH*i].
- in_valid  input  1  input_data holds the window result for the current raster position.
- output_data  output  D_WIDTH*CHANNELS  retained result, same channel packing as input_data.
- valid  output  1  output_data holds a retained result.
- frame_done  output  1  asserted together with valid on the last retained result of the frame, at output (OUT_SIZE-1, OUT_SIZE-1).

Behaviour:
- Reset (asynchronous, rst_n=0), all registers cleared immediately:
  - output_data=0, valid=0, frame_done=0.
  - col=row=0, col_phase=row_phase=0.
- Counter widths: col and row are LOG2(IMAGE_SIZE) bits; phase counters are LOG2(STRIDE) bits, minimum 1 bit.
- clk_en=0: no register changes, including the output registers. Outputs hold their values. Downstream samples only on clk_en=1 cycles.
- Accepted beat: clk_en=1 and in_valid=1. Each accepted beat corresponds to input raster position (row, col), starting at (0,0).
- Position advance per accepted beat:
  - col increments. At col=IMAGE_SIZE-1 it wraps to 0 and row increments.
  - At row=IMAGE_SIZE-1 and col=IMAGE_SIZE-1 both wrap to 0, and the next frame starts immediately with no gap.
- Phase counters (replace modulo arithmetic; no dividers allowed):
  - col_phase is held at 0 while col < FILTER_SIZE-1. After that it counts 0..STRIDE-1 cyclically on each accepted beat, and is forced to 0 on col wrap.
  - row_phase behaves the same way, advancing on row increments only, and is forced to 0 on frame wrap.
- Keep condition:
  - col >= FILTER_SIZE-1 and row >= FILTER_SIZE-1 and col_phase=0 and row_phase=0.
  - Trailing columns/rows that cannot start a full stride group are still kept whenever the keep condition holds. OUT_SIZE uses floor division, so the final kept column is FILTER_SIZE-1+(OUT_SIZE-1)*STRIDE. Positions beyond it are dropped.
  - Position test: keep only if col <= FILTER_SIZE-1+(OUT_SIZE-1)*STRIDE, and the same bound applies to row.
- Output registers, on every clk_en=1 edge:
  - valid <= accepted & keep.
  - output_data <= input_data when accepted & keep, otherwise holds its previous value.
  - frame_done <= accepted & keep & (row,col) equal to the last kept position.
- Latency: exactly one clk_en-qualified cycle from accepted input to output. No backpressure. The block never stalls the pooling layer.
- in_valid=0 with clk_en=1: position does not advance, valid and frame_done drop to 0, output_data holds.
- Reset mid-frame: counters return to (0,0). The next accepted beat is treated as pixel (0,0) of a new frame. Partial-frame outputs are not flushed.
- Parameter constraints (elaboration error otherwise):
  - STRIDE >= 1
  - FILTER_SIZE >= 1
  - IMAGE_SIZE >= FILTER_SIZE
- STRIDE=1 degenerates to keep-all-full-windows.

Test Plan:
- IMAGE_SIZE=6, FILTER_SIZE=2, STRIDE=2, CHANNELS=1, D_WIDTH=8; stream 36 beats with data=beat index (clk_en=1, in_valid=1) -> valid pulses carry 7,9,11,19,21,23,31,33,35 one cycle after the corresponding input; frame_done only with 35; exactly 9 valid cycles.
- Same config, in_valid deasserted for 3 cycles after beat 8 and clk_en low for 2 cycles after beat 20 -> identical output sequence; outputs frozen during clk_en=0; no position skipped or duplicated.
- Two back-to-back frames (72 beats) -> 18 outputs; the second frame starts with 7 (beat 43); frame_done with beats 35 and 71.
- IMAGE_SIZE=7, FILTER_SIZE=3, STRIDE=2 (OUT_SIZE=3) -> kept (r,c) in {2,4,6}^2, i.e. indices 16,18,20,30,32,34,44,46,48; frame_done with 48.
- IMAGE_SIZE=7, FILTER_SIZE=2, STRIDE=3 (OUT_SIZE=2) -> kept indices 8,11,29,32; column/row 6 dropped; frame_done with 32.
- rst_n asserted asynchronously mid-cycle at beat 15 of frame 1 -> valid, frame_done, and output_data are 0 immediately; after release, the next beats restart at (0,0) and the first output is beat index 7 of the new stream.
